mem_bus_responder: RTL and testbench

Shared-bus far end for the 4-core MESI system: arbitrates the per-core processor and snoop bus requests and acts as main memory on the common bus. It answers BusRd/BusRdX fills unless a snooping cache aborts, accepts write-backs signalled by Mem_wr, and aggregates per-core Invalidation_done into All_Invalidation_done. One instance sits beside the four cache units on Address_Com/Data_Bus_Com.

---
 rtl/mem_bus_if.sv | 26 ++
 rtl/mem_bus_responder.sv | 108 ++++++++++
 tb/tb_mem_bus_responder.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: shared MESI bus handshake, command and invalidation signals between the cores and the memory responder
interface mem_bus_if #(parameter int ADDR_W = 32);
   logic [3:0]        Com_Bus_Req_proc;
   logic [3:0]        Com_Bus_Gnt_proc;
   logic [3:0]        Com_Bus_Req_snoop;
   logic [3:0]        Com_Bus_Gnt_snoop;
   logic [ADDR_W-1:0] Address_Com;
   logic              BusRd;
   logic              BusRdX;
   logic              Invalidate;
   logic              Mem_wr;
   logic              Mem_oprn_abort;
   logic              Mem_write_done;
   logic [3:0]        Invalidation_done;
   logic              All_Invalidation_done;
   modport master (
      output Com_Bus_Req_proc, Com_Bus_Req_snoop, Address_Com, BusRd, BusRdX, Invalidate, Mem_wr,
             Mem_oprn_abort, Invalidation_done,
      input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_write_done, All_Invalidation_done
   );
   modport slave (
      input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Address_Com, BusRd, BusRdX, Invalidate, Mem_wr,
             Mem_oprn_abort, Invalidation_done,
      output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_write_done, All_Invalidation_done
   );
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: 4-core MESI bus arbiter and main memory; define ARB_ROUND_ROBIN_EN for round-robin processor arbitration (default fixed priority, core 0 highest)
module mem_bus_responder #(
   parameter int ADDR_W      = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int MEM_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_if.slave          bus,
   inout  tri   [ADDR_W-1:0] Data_Bus_Com,
   inout  tri                Data_in_Bus
);
   localparam int IW = $clog2(MEM_DEPTH);
   localparam logic [3:0] LAT = 4'(MEM_LATENCY);
   typedef enum logic [2:0] {IDLE, GRANTED, RD_WAIT, RD_DRIVE, RD_ABORT, WR_WAIT, WR_DONE} state_t;
   state_t            state, next_state;
   logic [3:0]        cnt, next_cnt, gnt, next_gnt, sgnt, next_sgnt, snoop_cand;
   logic [1:0]        rr, win, k;
   logic              all_inv, held, mem_we, addr_unused;
   logic [IW-1:0]     idx;
   logic [ADDR_W-1:0] mem [MEM_DEPTH];
   assign idx = bus.Address_Com[IW-1:0];
   assign addr_unused = ^bus.Address_Com[ADDR_W-1:IW];
   assign held = |(gnt & bus.Com_Bus_Req_proc);
   // Processor arbitration: first requester found scanning upward from the priority pointer
   always_comb begin
      win = 2'd0;
      k = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         k = rr + 2'(i);
         if (bus.Com_Bus_Req_proc[k]) win = k;
      end
   end
   // Bus transaction FSM; losing the owner's request from any busy state abandons the transaction
   always_comb begin
      next_state = state;
      next_cnt = cnt;
      next_gnt = gnt;
      mem_we = 1'b0;
      if (state == IDLE) begin
         if (|bus.Com_Bus_Req_proc) begin
            next_gnt = 4'b1 << win;
            next_state = GRANTED;
         end
      end else if (!held) begin
         next_gnt = '0;
         next_state = IDLE;
      end else begin
         case (state)
            GRANTED:
               if (bus.Mem_wr) begin
                  next_cnt = LAT;
                  next_state = WR_WAIT;
               end else if (bus.BusRd || bus.BusRdX) begin
                  next_cnt = LAT;
                  next_state = RD_WAIT;
               end
            RD_WAIT:
               if (bus.Mem_oprn_abort) next_state = RD_ABORT;
               else if (cnt == 4'd0) next_state = RD_DRIVE;
               else next_cnt = cnt - 4'd1;
            WR_WAIT:
               if (cnt == 4'd0) begin
                  mem_we = 1'b1;
                  next_state = WR_DONE;
               end else next_cnt = cnt - 4'd1;
            WR_DONE:
               if (!bus.Mem_wr) next_state = GRANTED;
            default: ;
         endcase
      end
   end
   // Snoop grant follows the next processor grant so both end on the same edge
   assign snoop_cand = bus.Com_Bus_Req_snoop & ~next_gnt;
   assign next_sgnt = ~|next_gnt ? 4'b0 : |(sgnt & snoop_cand) ? sgnt : snoop_cand & (~snoop_cand + 4'd1);
   // State, grants and the invalidation summary register
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= 4'd0;
         gnt <= 4'b0;
         sgnt <= 4'b0;
         all_inv <= 1'b0;
      end else begin
         state <= next_state;
         cnt <= next_cnt;
         gnt <= next_gnt;
         sgnt <= next_sgnt;
         all_inv <= bus.Invalidate && |gnt && &(bus.Invalidation_done | gnt);
      end
`ifdef ARB_ROUND_ROBIN_EN
   // Round-robin pointer moves just past each new winner
   always_ff @(posedge clk or posedge rst)
      if (rst) rr <= 2'd0;
      else if (state == IDLE && |bus.Com_Bus_Req_proc) rr <= win + 2'd1;
`else
   assign rr = 2'd0;
`endif
   // Memory array keeps its contents across reset
   always_ff @(posedge clk)
      if (mem_we) mem[idx] <= Data_Bus_Com;
   assign bus.Com_Bus_Gnt_proc = gnt;
   assign bus.Com_Bus_Gnt_snoop = sgnt;
   assign bus.Mem_write_done = state == WR_DONE;
   assign bus.All_Invalidation_done = all_inv;
   assign Data_Bus_Com = state == RD_DRIVE ? mem[idx] : 'z;
   assign Data_in_Bus = state == RD_DRIVE ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: randomized self-checking bench for mem_bus_responder against a behavioural bus/memory model
module tb_mem_bus_responder;
   localparam int LAT = 4;
   localparam int RD_CYC = LAT + 2;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   tri   [31:0] data_bus;
   tri          data_in_bus;
   logic        tb_drv = 1'b0;
   logic [31:0] tb_data = '0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          rr_ptr = 0;
   logic [31:0] ref_mem [int];
   mem_bus_if #(.ADDR_W(32)) bus ();
   assign data_bus = tb_drv ? tb_data : 'z;
   always #5 clk = ~clk;
   mem_bus_responder #(.ADDR_W(32), .MEM_DEPTH(256), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus), .Data_Bus_Com(data_bus), .Data_in_Bus(data_in_bus));

   function automatic int exp_winner(input logic [3:0] m);
`ifdef ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 4; i++) if (m[(rr_ptr + i) % 4]) return (rr_ptr + i) % 4;
`else
      for (int i = 0; i < 4; i++) if (m[i]) return i;
`endif
      return 0;
   endfunction

   task automatic quiet();
      bus.Com_Bus_Req_proc = '0;
      bus.Com_Bus_Req_snoop = '0;
      bus.Address_Com = '0;
      bus.BusRd = 1'b0;
      bus.BusRdX = 1'b0;
      bus.Invalidate = 1'b0;
      bus.Mem_wr = 1'b0;
      bus.Mem_oprn_abort = 1'b0;
      bus.Invalidation_done = '0;
      tb_drv = 1'b0;
   endtask

   task automatic settle();
      quiet();
      repeat (2) @(negedge clk);
   endtask

   task automatic get_grant(input int c, output int cyc);
      bus.Com_Bus_Req_proc[c] = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.Com_Bus_Gnt_proc !== 4'(1 << c) && cyc < 20);
      rr_ptr = (c + 1) % 4;
   endtask

   task automatic do_write(input int c, input logic [31:0] a, input logic [31:0] d, output int g, output int w);
      get_grant(c, g);
      bus.Address_Com = a;
      bus.Mem_wr = 1'b1;
      tb_data = d;
      tb_drv = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (bus.Mem_write_done !== 1'b1 && w < 40);
      ref_mem[int'(a & 32'hFF)] = d;
      settle();
   endtask

   task automatic do_read(input int c, input logic [31:0] a, input bit rdx, output int g, output int r,
                          output logic [31:0] rd);
      get_grant(c, g);
      bus.Address_Com = a;
      bus.BusRd = !rdx;
      bus.BusRdX = rdx;
      r = 0;
      do begin
         @(negedge clk);
         r++;
         bus.BusRd = 1'b0;
         bus.BusRdX = 1'b0;
      end while (data_in_bus !== 1'b1 && r < 40);
      rd = data_bus;
   endtask

   task automatic test_reset();
      quiet();
      rst = 1'b1;
      bus.Com_Bus_Req_proc = 4'b1010;
      bus.Com_Bus_Req_snoop = 4'b0101;
      bus.Invalidate = 1'b1;
      bus.Invalidation_done = 4'hF;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.Com_Bus_Gnt_proc !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_gnt_proc: got %b want 0000", bus.Com_Bus_Gnt_proc);
      end
      n_checks++;
      if (bus.Com_Bus_Gnt_snoop !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_gnt_snoop: got %b want 0000", bus.Com_Bus_Gnt_snoop);
      end
      n_checks++;
      if (bus.Mem_write_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_write_done: got %b want 0", bus.Mem_write_done);
      end
      n_checks++;
      if (bus.All_Invalidation_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_all_inv: got %b want 0", bus.All_Invalidation_done);
      end
      n_checks++;
      if (data_in_bus === 1'b1) begin
         n_fail++;
         $display("FAIL reset_data_in_bus: got %b want released", data_in_bus);
      end
      quiet();
      rst = 1'b0;
      rr_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int cw, cr, g, w, r;
      logic [31:0] a, d, ra, rd, want;
      for (int t = 0; t < 6; t++) begin
         cw = t == 0 ? 2 : int'($urandom_range(0, 3));
         cr = t == 0 ? 1 : int'($urandom_range(0, 3));
         a = t == 0 ? 32'h10 : $urandom;
         d = t == 0 ? 32'hDEADBEEF : ($urandom | 32'h1);
         do_write(cw, a, d, g, w);
         n_checks++;
         if (g !== 1) begin
            n_fail++;
            $display("FAIL wr_grant_latency[%0d]: got %0d want 1", t, g);
         end
         n_checks++;
         if (w !== RD_CYC) begin
            n_fail++;
            $display("FAIL wr_done_latency[%0d]: got %0d want %0d", t, w, RD_CYC);
         end
         ra = t == 0 ? a : (($urandom & 32'hFFFFFF00) | (a & 32'hFF));
         want = ref_mem[int'(ra & 32'hFF)];
         do_read(cr, ra, t[0], g, r, rd);
         n_checks++;
         if (r !== RD_CYC) begin
            n_fail++;
            $display("FAIL rd_latency[%0d]: got %0d want %0d", t, r, RD_CYC);
         end
         n_checks++;
         if (rd !== want) begin
            n_fail++;
            $display("FAIL rd_data[%0d]: got %h want %h", t, rd, want);
         end
         bus.Com_Bus_Req_proc = '0;
         @(negedge clk);
         n_checks++;
         if (data_in_bus === 1'b1 || bus.Com_Bus_Gnt_proc !== 4'b0) begin
            n_fail++;
            $display("FAIL rd_release[%0d]: got din=%b gnt=%b want released, 0000", t, data_in_bus,
                     bus.Com_Bus_Gnt_proc);
         end
         settle();
      end
   endtask

   task automatic test_abort();
      int ab_at[3] = '{2, LAT, LAT + 1};
      int g, w;
      logic [31:0] a, d;
      for (int s = 0; s < 3; s++) begin
         a = 32'($urandom_range(0, 255));
         d = $urandom | 32'h8000_0000;
         do_write(3, a, d, g, w);
         get_grant(0, g);
         bus.Address_Com = a;
         bus.BusRdX = 1'b1;
         for (int cyc = 1; cyc <= RD_CYC + 3; cyc++) begin
            @(negedge clk);
            bus.BusRdX = 1'b0;
            n_checks++;
            if (data_in_bus === 1'b1 || data_bus === d) begin
               n_fail++;
               $display("FAIL abort_no_drive[%0d] cyc %0d: got din=%b data=%h want released", s, cyc,
                        data_in_bus, data_bus);
            end
            bus.Mem_oprn_abort = cyc == ab_at[s];
         end
         n_checks++;
         if (bus.Com_Bus_Gnt_proc !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_grant_held[%0d]: got %b want 0001", s, bus.Com_Bus_Gnt_proc);
         end
         bus.Com_Bus_Req_proc = '0;
         @(negedge clk);
         n_checks++;
         if (bus.Com_Bus_Gnt_proc !== 4'b0) begin
            n_fail++;
            $display("FAIL abort_grant_drop[%0d]: got %b want 0000", s, bus.Com_Bus_Gnt_proc);
         end
         settle();
      end
   endtask

   task automatic test_arbitration();
      logic [3:0] m;
      int w;
      for (int t = 0; t < 12; t++) begin
         m = t < 4 ? 4'b1001 : 4'($urandom_range(1, 15));
         bus.Com_Bus_Req_proc = m;
         @(negedge clk);
         w = exp_winner(m);
         n_checks++;
         if (bus.Com_Bus_Gnt_proc !== 4'(1 << w)) begin
            n_fail++;
            $display("FAIL arb[%0d] req %b: got %b want %b", t, m, bus.Com_Bus_Gnt_proc, 4'(1 << w));
         end
         rr_ptr = (w + 1) % 4;
         settle();
      end
   endtask

   task automatic test_invalidate();
      logic [3:0] inv;
      logic       en, want;
      int         c, g;
      get_grant(1, g);
      bus.Invalidate = 1'b1;
      bus.Invalidation_done = 4'b0101;
      @(negedge clk);
      n_checks++;
      if (bus.All_Invalidation_done !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_partial: got %b want 0", bus.All_Invalidation_done);
      end
      bus.Invalidation_done = 4'b1101;
      @(negedge clk);
      n_checks++;
      if (bus.All_Invalidation_done !== 1'b1) begin
         n_fail++;
         $display("FAIL inv_owner_ignored: got %b want 1", bus.All_Invalidation_done);
      end
      settle();
      c = int'($urandom_range(0, 3));
      get_grant(c, g);
      for (int t = 0; t < 12; t++) begin
         en = 1'($urandom_range(0, 1));
         inv = 4'($urandom_range(0, 15)) | ((t % 3 == 0) ? 4'hF : 4'h0);
         bus.Invalidate = en;
         bus.Invalidation_done = inv;
         want = en && ((inv | 4'(1 << c)) == 4'hF);
         @(negedge clk);
         n_checks++;
         if (bus.All_Invalidation_done !== want) begin
            n_fail++;
            $display("FAIL inv_rand[%0d] core %0d inv %b en %b: got %b want %b", t, c, inv, en,
                     bus.All_Invalidation_done, want);
         end
      end
      settle();
   endtask

   task automatic test_snoop();
      logic [3:0] fixed_s[4] = '{4'b0100, 4'b0101, 4'b0110, 4'b0011};
      logic [3:0] s, cand, want;
      int g;
      want = 4'b0;
      get_grant(0, g);
      bus.Address_Com = 32'h20;
      bus.BusRd = 1'b1;
      for (int t = 0; t < 14; t++) begin
         s = t < 4 ? fixed_s[t] : 4'($urandom_range(0, 15));
         bus.Com_Bus_Req_snoop = s;
         cand = s & 4'b1110;
         if ((want & cand) == 4'b0) begin
            want = 4'b0;
            for (int i = 3; i >= 0; i--) if (cand[i]) want = 4'(1 << i);
         end
         @(negedge clk);
         bus.BusRd = 1'b0;
         n_checks++;
         if (bus.Com_Bus_Gnt_snoop !== want || bus.Com_Bus_Gnt_proc !== 4'b0001) begin
            n_fail++;
            $display("FAIL snoop[%0d] req %b: got snoop %b proc %b want %b 0001", t, s,
                     bus.Com_Bus_Gnt_snoop, bus.Com_Bus_Gnt_proc, want);
         end
      end
      bus.Com_Bus_Req_snoop = 4'b1110;
      bus.Com_Bus_Req_proc = '0;
      @(negedge clk);
      n_checks++;
      if (bus.Com_Bus_Gnt_snoop !== 4'b0 || bus.Com_Bus_Gnt_proc !== 4'b0) begin
         n_fail++;
         $display("FAIL snoop_release: got snoop %b proc %b want 0000 0000", bus.Com_Bus_Gnt_snoop,
                  bus.Com_Bus_Gnt_proc);
      end
      @(negedge clk);
      n_checks++;
      if (bus.Com_Bus_Gnt_snoop !== 4'b0) begin
         n_fail++;
         $display("FAIL snoop_no_owner: got %b want 0000", bus.Com_Bus_Gnt_snoop);
      end
      settle();
   endtask

   task automatic test_back_to_back();
      int c, g, w, r, l;
      logic [31:0] a, d, rd;
      c = int'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 255));
      d = $urandom | 32'h1;
      get_grant(c, g);
      bus.Address_Com = a;
      bus.Mem_wr = 1'b1;
      tb_data = d;
      tb_drv = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (bus.Mem_write_done !== 1'b1 && w < 40);
      ref_mem[int'(a & 32'hFF)] = d;
      n_checks++;
      if (w !== RD_CYC) begin
         n_fail++;
         $display("FAIL b2b_write_latency: got %0d want %0d", w, RD_CYC);
      end
      bus.Mem_wr = 1'b0;
      tb_drv = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.Mem_write_done !== 1'b0 || bus.Com_Bus_Gnt_proc !== 4'(1 << c)) begin
         n_fail++;
         $display("FAIL b2b_done_drop: got done %b gnt %b want 0 %b", bus.Mem_write_done,
                  bus.Com_Bus_Gnt_proc, 4'(1 << c));
      end
      bus.BusRd = 1'b1;
      r = 0;
      do begin
         @(negedge clk);
         r++;
         bus.BusRd = 1'b0;
      end while (data_in_bus !== 1'b1 && r < 40);
      rd = data_bus;
      n_checks++;
      if (r !== RD_CYC || rd !== ref_mem[int'(a & 32'hFF)]) begin
         n_fail++;
         $display("FAIL b2b_read: got %0d cycles data %h want %0d cycles data %h", r, rd, RD_CYC,
                  ref_mem[int'(a & 32'hFF)]);
      end
      settle();
      bus.Com_Bus_Req_proc = 4'b0110;
      @(negedge clk);
      w = exp_winner(4'b0110);
      rr_ptr = (w + 1) % 4;
      l = w == 1 ? 2 : 1;
      n_checks++;
      if (bus.Com_Bus_Gnt_proc !== 4'(1 << w)) begin
         n_fail++;
         $display("FAIL handoff_first: got %b want %b", bus.Com_Bus_Gnt_proc, 4'(1 << w));
      end
      bus.Com_Bus_Req_proc[w] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.Com_Bus_Gnt_proc !== 4'b0) begin
         n_fail++;
         $display("FAIL handoff_gap: got %b want 0000", bus.Com_Bus_Gnt_proc);
      end
      @(negedge clk);
      rr_ptr = (l + 1) % 4;
      n_checks++;
      if (bus.Com_Bus_Gnt_proc !== 4'(1 << l)) begin
         n_fail++;
         $display("FAIL handoff_second: got %b want %b", bus.Com_Bus_Gnt_proc, 4'(1 << l));
      end
      settle();
   endtask

   task automatic test_reset_mid_read();
      int g, w, r;
      logic [31:0] a, d, rd;
      a = 32'($urandom_range(0, 255));
      d = $urandom | 32'h1;
      do_write(2, a, d, g, w);
      get_grant(1, g);
      bus.Address_Com = a;
      bus.BusRd = 1'b1;
      @(negedge clk);
      bus.BusRd = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.Com_Bus_Gnt_proc !== 4'b0 || bus.Com_Bus_Gnt_snoop !== 4'b0) begin
         n_fail++;
         $display("FAIL midrd_rst_grants: got %b %b want 0000 0000", bus.Com_Bus_Gnt_proc,
                  bus.Com_Bus_Gnt_snoop);
      end
      n_checks++;
      if (data_in_bus === 1'b1) begin
         n_fail++;
         $display("FAIL midrd_rst_din: got %b want released", data_in_bus);
      end
      @(negedge clk);
      quiet();
      rst = 1'b0;
      rr_ptr = 0;
      @(negedge clk);
      do_read(3, a, 1'b0, g, r, rd);
      n_checks++;
      if (r !== RD_CYC || rd !== d) begin
         n_fail++;
         $display("FAIL midrd_mem_kept: got %0d cycles data %h want %0d cycles data %h", r, rd, RD_CYC, d);
      end
      settle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_abort();
      test_arbitration();
      test_invalidate();
      test_snoop();
      test_back_to_back();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
